// File: rtl/microwave_timer_ctrl.sv
// Sequencing controller for a four-digit BCD MM:SS countdown chain: keypad entry,
// load/count strobes to the chain, magnetron and done outputs, door interlock.
module microwave_timer_ctrl (
  input  logic        clk,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        door_closed,
  input  logic        sec_tick,
  input  logic        timer_zero,
  output logic [15:0] data,
  output logic        loadn,
  output logic        en,
  output logic        mag_on,
  output logic        done,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENTRY  = 3'd1,
    S_LOAD   = 3'd2,
    S_COOK   = 3'd3,
    S_PAUSE  = 3'd4,
    S_CANCEL = 3'd5,
    S_DONE   = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_entry;
  logic [15:0] w_entry_nxt;
  logic        w_key_ok;
  logic [3:0]  w_sec_tens;

  // key_valid is a one-cycle strobe with no back-pressure: a digit is either
  // consumed on the edge where key_valid is high or it is lost.
  assign w_key_ok = key_valid && (key_digit <= 4'd9);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= S_IDLE;
      r_entry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_entry <= w_entry_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_entry_nxt = r_entry;
    case (r_state)
      S_IDLE, S_ENTRY: begin
        // Higher-priority pulses consume the cycle even when they have no effect here.
        if (clear) begin
          w_state_nxt = S_IDLE;
          w_entry_nxt = '0;
        end else if (stop) begin
          w_state_nxt = r_state;
        end else if (start) begin
          if (door_closed) begin
            if (r_entry == 16'h0000) w_entry_nxt = 16'h0030;
            w_state_nxt = S_LOAD;
          end
        end else if (w_key_ok) begin
          w_entry_nxt = {r_entry[11:0], key_digit};
          w_state_nxt = S_ENTRY;
        end
      end
      S_LOAD: w_state_nxt = S_COOK;
      S_COOK: begin
        if (clear)                   w_state_nxt = S_CANCEL;
        else if (stop || !door_closed) w_state_nxt = S_PAUSE;
        else if (timer_zero)         w_state_nxt = S_DONE;
      end
      S_PAUSE: begin
        if (clear || stop)                w_state_nxt = S_CANCEL;
        else if (start && door_closed)    w_state_nxt = S_COOK;
      end
      S_CANCEL: begin
        w_state_nxt = S_IDLE;
        w_entry_nxt = '0;
      end
      S_DONE: begin
        if (start || stop || clear || key_valid || !door_closed) begin
          w_state_nxt = S_IDLE;
          w_entry_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_entry_nxt = '0;
      end
    endcase
  end

  // Seconds-tens digit is clamped on the way out; the entry register keeps what was typed.
  assign w_sec_tens = (r_entry[7:4] > 4'd5) ? 4'd5 : r_entry[7:4];
  assign data   = (r_state == S_CANCEL) ? 16'h0000 : {r_entry[15:8], w_sec_tens, r_entry[3:0]};
  assign loadn  = !((r_state == S_LOAD) || (r_state == S_CANCEL));
  assign mag_on = (r_state == S_COOK);
  assign done   = (r_state == S_DONE);
  assign state  = r_state;
  assign en     = (r_state == S_COOK) && sec_tick && !timer_zero && door_closed && !stop && !clear;

endmodule
